// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time request/response sequencer around the external combinational 32-bit ALU.
// Define ALU_SEQUENCER_MUL_EN to build the iterative shift-add multiply (op 9); otherwise op 9 traps as illegal.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [2:0]  alu_command,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  input  logic [31:0] alu_result,
  input  logic        alu_iszero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [1:0]  out_status
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_XOR = 3'd2;
  localparam logic [2:0] CMD_SLT = 3'd3;
  localparam logic [2:0] CMD_AND = 3'd4;
  localparam logic [2:0] CMD_NOR = 3'd6;
  localparam logic [2:0] CMD_OR  = 3'd7;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_OVF     = 2'd1;
  localparam logic [1:0] ST_ILLEGAL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_SEQUENCER_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  // Map an opcode onto the ALU command encoding; anything not single-pass maps to ADD.
  function automatic logic [2:0] op_to_cmd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDU: op_to_cmd = CMD_ADD;
      OP_SUB, OP_SUBU: op_to_cmd = CMD_SUB;
      OP_AND:          op_to_cmd = CMD_AND;
      OP_OR:           op_to_cmd = CMD_OR;
      OP_XOR:          op_to_cmd = CMD_XOR;
      OP_NOR:          op_to_cmd = CMD_NOR;
      OP_SLT:          op_to_cmd = CMD_SLT;
      OP_MUL:          op_to_cmd = CMD_ADD;
      default:         op_to_cmd = CMD_ADD;
    endcase
  endfunction

  state_t      state_r, state_n;
  logic [3:0]  op_r, op_n;
  logic [2:0]  cmd_n;
  logic [31:0] opa_n, opb_n;
  logic        in_ready_n, out_valid_n, zero_n;
  logic [31:0] result_n;
  logic [1:0]  status_n;
  logic [31:0] exec_result_s;
  logic [1:0]  exec_status_s;
  logic        accept_s, respond_s;
  logic        unused_s;
`ifdef ALU_SEQUENCER_MUL_EN
  logic [31:0] acc_r, acc_n, m_r, m_n, q_r, q_n;
  logic [4:0]  cnt_r, cnt_n;
`endif

  assign accept_s  = in_valid & in_ready;
  assign respond_s = out_valid & out_ready;
  // Zero flag is derived from the registered result, so the ALU's own flag is not needed.
  assign unused_s  = alu_iszero;

  // Result correction and status for single-pass ops; the operand registers still hold a and b in EXEC.
  always_comb begin
    exec_result_s = alu_result;
    exec_status_s = ST_OK;
    case (op_r)
      OP_ADD: begin
        if (alu_overflow) begin
          exec_status_s = ST_OVF;
        end else begin
          exec_status_s = ST_OK;
        end
      end
      OP_SUB: begin
        if ((alu_operand_a[31] != alu_operand_b[31]) && (alu_result[31] != alu_operand_a[31])) begin
          exec_status_s = ST_OVF;
        end else begin
          exec_status_s = ST_OK;
        end
      end
      OP_SLT: begin
        if (alu_operand_a[31] != alu_operand_b[31]) begin
          exec_result_s = {31'd0, alu_operand_a[31]};
        end else begin
          exec_result_s = alu_result;
        end
      end
      OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR: exec_status_s = ST_OK;
      default: begin
        exec_result_s = 32'd0;
        exec_status_s = ST_ILLEGAL;
      end
    endcase
  end

  // Next-state and next register values; ALU inputs fall back to ADD, 0, 0 unless the next state uses the ALU.
  always_comb begin
    state_n     = state_r;
    op_n        = op_r;
    cmd_n       = CMD_ADD;
    opa_n       = 32'd0;
    opb_n       = 32'd0;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    result_n    = out_result;
    zero_n      = out_zero;
    status_n    = out_status;
`ifdef ALU_SEQUENCER_MUL_EN
    acc_n = acc_r;
    m_n   = m_r;
    q_n   = q_r;
    cnt_n = cnt_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          op_n       = in_op;
          in_ready_n = 1'b0;
          if (in_op <= OP_SLT) begin
            state_n = S_EXEC;
            cmd_n   = op_to_cmd(in_op);
            opa_n   = in_a;
            opb_n   = in_b;
`ifdef ALU_SEQUENCER_MUL_EN
          end else if (in_op == OP_MUL) begin
            state_n = S_MUL;
            acc_n   = 32'd0;
            m_n     = in_a;
            q_n     = in_b;
            cnt_n   = 5'd0;
            cmd_n   = CMD_ADD;
            opa_n   = 32'd0;
            opb_n   = in_b[0] ? in_a : 32'd0;
`endif
          end else begin
            state_n     = S_DONE;
            out_valid_n = 1'b1;
            result_n    = 32'd0;
            zero_n      = 1'b1;
            status_n    = ST_ILLEGAL;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_EXEC: begin
        state_n     = S_DONE;
        out_valid_n = 1'b1;
        result_n    = exec_result_s;
        zero_n      = (exec_result_s == 32'd0);
        status_n    = exec_status_s;
      end
`ifdef ALU_SEQUENCER_MUL_EN
      S_MUL: begin
        acc_n = alu_result;
        m_n   = m_r << 1;
        q_n   = q_r >> 1;
        cnt_n = cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          state_n     = S_DONE;
          out_valid_n = 1'b1;
          result_n    = alu_result;
          zero_n      = (alu_result == 32'd0);
          status_n    = ST_OK;
        end else begin
          // Present the next partial-product add straight from the updated multiplier registers.
          cmd_n = CMD_ADD;
          opa_n = alu_result;
          opb_n = q_r[1] ? (m_r << 1) : 32'd0;
        end
      end
`endif
      S_DONE: begin
        if (respond_s) begin
          state_n     = S_IDLE;
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n     = S_IDLE;
        in_ready_n  = 1'b1;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight op, even over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      op_r          <= 4'd0;
      alu_command   <= CMD_ADD;
      alu_operand_a <= 32'd0;
      alu_operand_b <= 32'd0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_zero      <= 1'b0;
      out_status    <= ST_OK;
`ifdef ALU_SEQUENCER_MUL_EN
      acc_r <= 32'd0;
      m_r   <= 32'd0;
      q_r   <= 32'd0;
      cnt_r <= 5'd0;
`endif
    end else begin
      state_r       <= state_n;
      op_r          <= op_n;
      alu_command   <= cmd_n;
      alu_operand_a <= opa_n;
      alu_operand_b <= opb_n;
      in_ready      <= in_ready_n;
      out_valid     <= out_valid_n;
      out_result    <= result_n;
      out_zero      <= zero_n;
      out_status    <= status_n;
`ifdef ALU_SEQUENCER_MUL_EN
      acc_r <= acc_n;
      m_r   <= m_n;
      q_r   <= q_n;
      cnt_r <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, arithmetic reference model, random and directed ops.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [2:0]  alu_command;
  logic [31:0] alu_operand_a, alu_operand_b;
  logic [31:0] alu_result;
  logic        alu_iszero;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [1:0]  out_status;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_command(alu_command), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_iszero(alu_iszero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_status(out_status)
  );

  // Combinational ALU: its SLT is the raw sign of a-b, which is wrong when the operand signs differ.
  logic [31:0] alu_diff;
  always_comb begin
    alu_diff     = alu_operand_a - alu_operand_b;
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    case (alu_command)
      3'd0: begin
        alu_result   = alu_operand_a + alu_operand_b;
        alu_overflow = (alu_operand_a[31] == alu_operand_b[31]) && (alu_result[31] != alu_operand_a[31]);
      end
      3'd1: begin
        alu_result   = alu_diff;
        alu_overflow = (alu_operand_a[31] != alu_operand_b[31]) && (alu_diff[31] != alu_operand_a[31]);
      end
      3'd2: alu_result = alu_operand_a ^ alu_operand_b;
      3'd3: alu_result = {31'd0, alu_diff[31]};
      3'd4: alu_result = alu_operand_a & alu_operand_b;
      3'd5: alu_result = ~(alu_operand_a & alu_operand_b);
      3'd6: alu_result = ~(alu_operand_a | alu_operand_b);
      3'd7: alu_result = alu_operand_a | alu_operand_b;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_iszero = (alu_result == 32'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: true signed arithmetic decides overflow; latency in cycles from accept to out_valid.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [1:0] st, output int lat);
    longint sa, sb, wide;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'd0;
    st  = 2'd0;
    lat = 2;
    case (op)
      4'd0: begin res = a + b; wide = sa + sb; st = (wide != longint'($signed(res))) ? 2'd1 : 2'd0; end
      4'd1: res = a + b;
      4'd2: begin res = a - b; wide = sa - sb; st = (wide != longint'($signed(res))) ? 2'd1 : 2'd0; end
      4'd3: res = a - b;
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd7: res = ~(a | b);
      4'd8: res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SEQUENCER_MUL_EN
      4'd9: begin res = a * b; lat = 33; end
`endif
      default: begin res = 32'd0; st = 2'd2; lat = 1; end
    endcase
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_idle_outputs(input string where);
    check_eq({where, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check_eq({where, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({where, "_alu_cmd"}, {29'd0, alu_command}, 32'd0);
    check_eq({where, "_alu_a"}, alu_operand_a, 32'd0);
    check_eq({where, "_alu_b"}, alu_operand_b, 32'd0);
  endtask

  // One full transaction starting just after a negedge; returns just after the handshake's following negedge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] exp_res;
    logic [1:0]  exp_st;
    int          exp_lat;
    int          lat;
    ref_model(op, a, b, exp_res, exp_st, exp_lat);
    check_idle_outputs("idle");
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      check_eq("busy_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check_eq($sformatf("latency_op%0d", op), lat, exp_lat);
    check_eq($sformatf("result_op%0d", op), out_result, exp_res);
    check_eq($sformatf("zero_op%0d", op), {31'd0, out_zero}, {31'd0, exp_res == 32'd0});
    check_eq($sformatf("status_op%0d", op), {30'd0, out_status}, {30'd0, exp_st});
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("stall_result", out_result, exp_res);
      check_eq("stall_status", {30'd0, out_status}, {30'd0, exp_st});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_state(input string where);
    check_idle_outputs(where);
    check_eq({where, "_result"}, out_result, 32'd0);
    check_eq({where, "_zero"}, {31'd0, out_zero}, 32'd0);
    check_eq({where, "_status"}, {30'd0, out_status}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd2, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(4'd2, 32'd5, 32'd5, 0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd8, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    run_op(4'd8, 32'd3, 32'd7, 0);
    run_op(4'd9, 32'h0000_FFFF, 32'h0001_0001, 0);
    run_op(4'd6, 32'hA5A5_0F0F, 32'h5A5A_F0F0, 5);
    run_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 2);

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), $urandom_range(0, 3));
    end

`ifdef ALU_SEQUENCER_MUL_EN
    // Reset in the middle of a multiply.
    in_valid = 1'b1; in_op = 4'd9; in_a = 32'h0001_2345; in_b = 32'h0000_0777;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mul_reset");
    run_op(4'd0, 32'd2, 32'd3, 0);
`endif

    // Reset while a response is pending, together with out_ready: reset wins.
    in_valid = 1'b1; in_op = 4'd5; in_a = 32'h0000_00F0; in_b = 32'h0000_000F;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    check_eq("pre_reset_result", out_result, 32'h0000_00FF);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0;
    check_reset_state("done_reset");
    run_op(4'd0, 32'd2, 32'd3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
